// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file with pending-write scoreboard.
package regfile_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set by a reservation at issue, cleared by a writeback release.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] addr_reserve,
    input  logic              rel,
    input  logic [ADDR_W-1:0] addr_rel,
    input  logic [DEPTH-1:0]  zero_mask,
    input  logic [ADDR_W-1:0] addr_one,
    input  logic [ADDR_W-1:0] addr_two,
    output logic              busy_one,
    output logic              busy_two
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (reserve) set_vec[addr_reserve] = 1'b1;
        if (rel)     clr_vec[addr_rel]     = 1'b1;
    end

    // Set is applied after clear so a same-cycle reserve beats the release.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= ((pending & ~clr_vec) | set_vec) & ~zero_mask;
    end

    assign busy_one = pending[addr_one];
    assign busy_two = pending[addr_two];

endmodule

// File: rtl/regfile_sb.sv
// Register file: two combinational read ports, one write port, zero register, optional
// write-to-read bypass, post-reset clearing sequencer and a RAW pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_one,
    input  logic [ADDR_W-1:0] addr_two,
    output logic [DATA_W-1:0] data_one,
    output logic [DATA_W-1:0] data_two,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_write,
    input  logic [DATA_W-1:0] data_write,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] addr_reserve,
    output logic              busy_one,
    output logic              busy_two,
    output logic              ready
);

    localparam int DEPTH = 2**ADDR_W;

    // we and reserve are single-cycle strobes with no back-pressure: each cycle they are
    // high in RUN is one accepted operation; in INIT (ready=0) they are discarded.

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              zero_write;
    logic              wr_en;
    logic              res_en;
    logic [DEPTH-1:0]  zero_mask;
    logic              sb_busy_one;
    logic              sb_busy_two;

    assign run        = (state == RUN);
    assign ready      = run;
    assign zero_write = (ZERO_REG != 0) && (addr_write == '0);
    assign wr_en      = run && we && !zero_write;
    assign res_en     = run && reserve;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // The counter stops in RUN, so it cannot wrap back into clearing on its own.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            INIT: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (&clr_cnt) state_next = RUN;
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) mem[clr_cnt]    <= '0;
            else if (wr_en)    mem[addr_write] <= data_write;
        end
    end

    // Zero register overrides the bypass; nothing is visible while clearing.
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] d;
        d = stored;
        if ((BYPASS != 0) && we && (addr_write == a)) d = data_write;
        if ((ZERO_REG != 0) && (a == '0))             d = '0;
        if (!run)                                     d = '0;
        return d;
    endfunction

    always_comb data_one = read_mux(addr_one, mem[addr_one]);
    always_comb data_two = read_mux(addr_two, mem[addr_two]);

    always_comb begin
        zero_mask    = '0;
        zero_mask[0] = (ZERO_REG != 0);
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .reserve      (res_en),
        .addr_reserve (addr_reserve),
        .rel          (run && we),
        .addr_rel     (addr_write),
        .zero_mask    (zero_mask),
        .addr_one     (addr_one),
        .addr_two     (addr_two),
        .busy_one     (sb_busy_one),
        .busy_two     (sb_busy_two)
    );

    assign busy_one = run && sb_busy_one;
    assign busy_two = run && sb_busy_two;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the processor register file: two asynchronous read ports and one synchronous write port, with configurable width and depth. It adds a hardwired zero register, optional write-to-read bypass, and a post-reset clearing sequencer. It also carries a per-entry pending-write scoreboard that the issue stage uses to detect RAW hazards. It sits between decode/issue (reads, reservations) and writeback (writes, releases).

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: 1 = entry 0 always reads 0, is never written, never reserved.
- BYPASS, 1: 1 = a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr_one  in  ADDR_W  read port one address.
- addr_two  in  ADDR_W  read port two address.
- data_one  out  DATA_W  read port one data (combinational).
- data_two  out  DATA_W  read port two data (combinational).
- we  in  1  write enable (writeback).
- addr_write  in  ADDR_W  write address.
- data_write  in  DATA_W  write data.
- reserve  in  1  mark addr_reserve as having a write in flight.
- addr_reserve  in  ADDR_W  entry to reserve.
- busy_one  out  1  pending bit of addr_one (combinational).
- busy_two  out  1  pending bit of addr_two (combinational).
- ready  out  1  clearing finished; the file is usable.

## Operation
- States: INIT, RUN.
- rst=1 (any state): next state INIT, clear counter = 0, all pending bits = 0, ready = 0.
- INIT, each edge with rst=0:
  - Write 0 to entry[counter], then counter+1.
  - After writing entry DEPTH-1: go to RUN and set ready=1.
  - we and reserve are ignored in INIT.
  - data_one, data_two, busy_one, busy_two all output 0.
- RUN:
  - we=1 writes data_write into entry[addr_write] and clears pending[addr_write].
  - reserve=1 sets pending[addr_reserve].
  - If reserve and we hit the same address in one cycle, the reservation wins: pending ends at 1, and the data is still written.
- Reads in RUN:
  - data_x = entry[addr_x].
  - If BYPASS=1, we=1 and addr_write==addr_x, then data_x = data_write.
  - If ZERO_REG=1 and addr_x==0, then data_x = 0; this overrides the bypass.
- busy_x = pending[addr_x], with no same-cycle bypass: a release or reserve in this cycle shows up next cycle.
- ZERO_REG=1:
  - Writes to entry 0 are dropped.
  - Reserves of entry 0 are dropped.
  - busy for address 0 is always 0.
- Both read ports are independent; the same address on both ports is legal.
- The counter is ADDR_W+1 bits wide, or ADDR_W bits with a terminal compare. It must never wrap back into INIT on its own.

## Timing
- Read latency is 0 cycles (combinational from address).
- Write latency is 1 edge. The value is visible without bypass on the cycle after the write edge.
- ready rises exactly DEPTH edges after the first edge sampled with rst=0. For defaults, that is the 32nd edge.
- Reset mid-INIT restarts clearing from entry 0. Reset mid-RUN clears all pending bits and re-clears all data.
- Reset values:
  - ready = 0.
  - data_one, data_two = 0.
  - busy_one, busy_two = 0.
  - All entries = 0 once ready=1.

## Structure
- Package regfile_pkg holds:
  - The state enum (INIT, RUN).
  - Default DATA_W and ADDR_W constants.
- Sub-module regfile_scoreboard (DEPTH pending bits):
  - Inputs: reserve/addr, release/addr, zero-reg mask.
  - Outputs: two busy lookups.
  - It is instantiated once.
- Storage array, bypass muxes and the clearing FSM live in regfile_sb.

## Test plan
- Init: assert rst 3 cycles, then release → ready=0 for 31 edges, ready=1 on edge 32; every address reads 0 after that.
- Write/read with BYPASS=1:
  - Write 0xDEADBEEF to r5 with addr_one=5 in the same cycle → data_one=0xDEADBEEF that cycle.
  - With BYPASS=0 → old value 0 that cycle, 0xDEADBEEF next cycle.
- Zero reg: write 0x1234 to r0 and reserve r0 → data_one(addr 0)=0 during and after; busy_one=0.
- Scoreboard:
  - Reserve r7 → busy_two=1 next cycle.
  - Then we to r7 with 0x55 → busy_two=0 next cycle, data_two=0x55.
  - Reserve and write r7 in the same cycle → busy stays 1.
- Reset mid-RUN:
  - With r3=0xA5A5A5A5 and r9 reserved, pulse rst for 1 cycle.
  - Required: ready=0, busy=0 immediately; r3 reads 0; ready returns after 32 edges.
  - we pulses during INIT have no effect.
- Reset mid-INIT: assert rst at edge 10 of clearing → counter restarts; ready rises 32 edges after the new release.
